intr_ctrl_v2: RTL and testbench
===============================

Name: intr_ctrl_v2

Overview:
Parametrised APB-programmable interrupt controller. It is the successor to the fixed 16-source controller, for SoC peripherals feeding one processor service port. Each source has:
- programmable priority
- enable mask
- level or edge sensing
- software-visible pending bit

A 3-state arbiter presents one winning source at a time and holds it until the processor acknowledges service.

Parameters:
- NUM_INTR, 16, number of interrupt sources (2..32).
- PRIO_W, 4, priority field width; priority 0 means the source is never granted.
- ID_W, $clog2(NUM_INTR), width of the source index.
- ADDR_W, $clog2(NUM_INTR+4), APB address width.

Ports:
- pclk_i  in  1  single clock; all state updates on rising edge.
- prst_i  in  1  reset, asynchronous, active-low; assertion clears all state immediately.
- paddr_i  in  ADDR_W  APB address.
- pwdata_i  in  32  APB write data.
- pwrite_i  in  1  APB write strobe.
- psel_i  in  1  APB select.
- penable_i  in  1  APB access phase.
- prdata_o  out  32  APB read data, valid while pready_o=1.
- pready_o  out  1  access-phase complete; zero wait states.
- pslverr_o  out  1  error response for an unmapped address.
- intr_active_i  in  NUM_INTR  raw interrupt lines.
- intr_to_service_o  out  ID_W  index of granted source.
- intr_valid_o  out  1  grant valid.
- intr_serviced_i  in  1  processor acknowledge of the current grant.

Behaviour:
- Reset (prst_i=0, async). Outputs and state on reset:
  - prdata_o=0, pready_o=0, pslverr_o=0, intr_to_service_o=0, intr_valid_o=0.
  - All PRIO=0, ENABLE=0, MODE=0, PENDING=0, edge-history register=0.
  - FSM=IDLE.
- Register map (word index = paddr_i):
  - 0..NUM_INTR-1: PRIO[n], bits [PRIO_W-1:0], RW.
  - NUM_INTR: ENABLE, bit n per source, RW.
  - NUM_INTR+1: MODE, bit n: 1=edge, 0=level, RW.
  - NUM_INTR+2: PENDING. Read returns the pending vector. Write-1-to-clear, edge sources only; writes to level bits are ignored.
  - NUM_INTR+3: STATUS, RO = {intr_valid_o at bit 31, intr_to_service_o at [ID_W-1:0]}.
  - Unused bits read 0. Writes to STATUS are ignored without error.
- APB access:
  - pready_o = psel_i & penable_i, combinational.
  - Write takes effect at the clock edge ending the access phase.
  - prdata_o is a combinational mux of the addressed register during the access phase, 0 otherwise.
  - paddr_i > NUM_INTR+3: pslverr_o=1 with pready_o; write discarded, read data 0.
- Pending update, every edge:
  - Level source: pending[n] <= intr_active_i[n].
  - Edge source: pending[n] set on sampled 0->1 (intr_active_i & ~hist); cleared by W1C, or by an acknowledge when n is the granted source.
  - If set and clear occur in the same cycle, set wins.
  - Writing MODE does not change pending; hist always tracks intr_active_i.
- Eligible[n] = pending[n] & ENABLE[n] & (PRIO[n]!=0).
- FSM:
  - IDLE: if any eligible source -> ARB.
  - ARB:
    - Winner = eligible source with the highest PRIO; ties go to the lowest index.
    - Register the winner into intr_to_service_o, set intr_valid_o=1, -> WAIT.
    - If nothing is eligible in ARB (cleared meanwhile) -> IDLE, no grant.
  - WAIT:
    - Hold intr_to_service_o and intr_valid_o stable. Later PRIO, ENABLE or pending changes do not retract or alter the grant.
    - On intr_serviced_i=1: intr_valid_o<=0, intr_to_service_o<=0, clear the granted edge pending bit, -> IDLE.
    - intr_serviced_i outside WAIT is ignored.
- Latency:
  - pending set at edge k, state ARB at edge k+1, intr_valid_o=1 after edge k+2.
  - Minimum gap between consecutive grants: 2 cycles with intr_valid_o=0 after the acknowledge edge.
- A level source still asserted after acknowledge is re-granted by normal arbitration.
- Reset mid-WAIT: grant dropped immediately; no acknowledge is expected.

Test Plan:
1. Reset, then read all registers -> every read returns 0; outputs 0; paddr_i=NUM_INTR+4 read -> pslverr_o=1, prdata_o=0.
2. Program PRIO[3]=5, PRIO[9]=7, ENABLE=0x0208, MODE=0; raise lines 3 and 9 together -> intr_to_service_o=9, intr_valid_o=1 two edges after pending. Acknowledge and drop line 9 -> next grant is 3.
3. PRIO[2]=PRIO[6]=4, both enabled and active -> grant 2 (lowest-index tie-break).
4. Source 5 in edge mode, enabled, PRIO=1: pulse line 5 for one cycle -> PENDING bit 5=1, grant 5. Acknowledge -> PENDING=0, no re-grant. Second pulse, then W1C 0x20 before ARB -> no grant.
5. During WAIT on source 4, write PRIO[4]=0 and raise a higher-priority source -> grant stays 4 until acknowledge, then the higher source is granted.
6. Assert prst_i=0 mid-WAIT, asynchronous to pclk_i -> intr_valid_o=0 without a clock edge; all registers read 0 after release.

Source files
------------

// File: rtl/intr_ctrl_v2.sv
// rtl/intr_ctrl_v2.sv - APB-programmable prioritised interrupt controller
// Per-source priority/enable/mode/pending with a grant held until acknowledged.
module intr_ctrl_v2 #(
  parameter int NUM_INTR = 16,
  parameter int PRIO_W   = 4,
  parameter int ID_W     = $clog2(NUM_INTR),
  parameter int ADDR_W   = $clog2(NUM_INTR + 4)
) (
  input  logic                pclk_i,
  input  logic                prst_i,
  input  logic [ADDR_W-1:0]   paddr_i,
  input  logic [31:0]         pwdata_i,
  input  logic                pwrite_i,
  input  logic                psel_i,
  input  logic                penable_i,
  output logic [31:0]         prdata_o,
  output logic                pready_o,
  output logic                pslverr_o,
  input  logic [NUM_INTR-1:0] intr_active_i,
  output logic [ID_W-1:0]     intr_to_service_o,
  output logic                intr_valid_o,
  input  logic                intr_serviced_i
);

  localparam logic [31:0] A_ENABLE  = 32'(NUM_INTR);
  localparam logic [31:0] A_MODE    = 32'(NUM_INTR + 1);
  localparam logic [31:0] A_PENDING = 32'(NUM_INTR + 2);
  localparam logic [31:0] A_STATUS  = 32'(NUM_INTR + 3);

  typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_WAIT} state_e;

  state_e              state_q, state_d;
  logic [PRIO_W-1:0]   prio_q [NUM_INTR];
  logic [PRIO_W-1:0]   prio_d [NUM_INTR];
  logic [NUM_INTR-1:0] enable_q, enable_d;
  logic [NUM_INTR-1:0] mode_q, mode_d;
  logic [NUM_INTR-1:0] pending_q, pending_d;
  logic [NUM_INTR-1:0] hist_q;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic                grant_vld_q, grant_vld_d;

  logic [31:0]         addr_w;
  logic                access, unmapped, wr_en;
  logic [NUM_INTR-1:0] eligible, w1c_mask, ack_mask;
  logic [ID_W-1:0]     win_id;
  logic [PRIO_W-1:0]   win_prio;
  logic                win_any;
  logic                unused_wdata;

  assign addr_w       = 32'(paddr_i);
  assign access       = psel_i & penable_i;
  assign unmapped     = addr_w > A_STATUS;
  assign wr_en        = access & pwrite_i & ~unmapped;
  assign pready_o     = access;
  assign pslverr_o    = access & unmapped;
  assign unused_wdata = ^pwdata_i;

  assign intr_valid_o      = grant_vld_q;
  assign intr_to_service_o = grant_id_q;

  always_comb begin
    prdata_o = '0;
    if (access && !unmapped) begin
      if (addr_w < A_ENABLE)        prdata_o = 32'(prio_q[addr_w[ID_W-1:0]]);
      else if (addr_w == A_ENABLE)  prdata_o = 32'(enable_q);
      else if (addr_w == A_MODE)    prdata_o = 32'(mode_q);
      else if (addr_w == A_PENDING) prdata_o = 32'(pending_q);
      else begin
        prdata_o     = 32'(grant_id_q);
        prdata_o[31] = grant_vld_q;
      end
    end
  end

  always_comb begin
    prio_d   = prio_q;
    enable_d = enable_q;
    mode_d   = mode_q;
    w1c_mask = '0;
    if (wr_en) begin
      if (addr_w < A_ENABLE)        prio_d[addr_w[ID_W-1:0]] = pwdata_i[PRIO_W-1:0];
      else if (addr_w == A_ENABLE)  enable_d = pwdata_i[NUM_INTR-1:0];
      else if (addr_w == A_MODE)    mode_d   = pwdata_i[NUM_INTR-1:0];
      else if (addr_w == A_PENDING) w1c_mask = pwdata_i[NUM_INTR-1:0] & mode_q;
    end
  end

  // Edge sources: a new rising edge outranks any clear in the same cycle.
  always_comb begin
    ack_mask = '0;
    if (state_q == ST_WAIT && intr_serviced_i) ack_mask[grant_id_q] = 1'b1;
    pending_d = (~mode_q & intr_active_i) |
                (mode_q & ((pending_q & ~(w1c_mask | ack_mask)) | (intr_active_i & ~hist_q)));
  end

  // Ascending scan with strict compare keeps the lowest index on equal priority.
  always_comb begin
    win_any  = 1'b0;
    win_id   = '0;
    win_prio = '0;
    for (int n = 0; n < NUM_INTR; n++) begin
      eligible[n] = pending_q[n] & enable_q[n] & (prio_q[n] != '0);
      if (eligible[n] && prio_q[n] > win_prio) begin
        win_any  = 1'b1;
        win_prio = prio_q[n];
        win_id   = ID_W'(n);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    grant_vld_d = grant_vld_q;
    case (state_q)
      ST_IDLE: if (|eligible) state_d = ST_ARB;
      ST_ARB: begin
        if (win_any) begin
          grant_id_d  = win_id;
          grant_vld_d = 1'b1;
          state_d     = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (intr_serviced_i) begin
          grant_id_d  = '0;
          grant_vld_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      state_q     <= ST_IDLE;
      for (int n = 0; n < NUM_INTR; n++) prio_q[n] <= '0;
      enable_q    <= '0;
      mode_q      <= '0;
      pending_q   <= '0;
      hist_q      <= '0;
      grant_id_q  <= '0;
      grant_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      enable_q    <= enable_d;
      mode_q      <= mode_d;
      pending_q   <= pending_d;
      hist_q      <= intr_active_i;
      grant_id_q  <= grant_id_d;
      grant_vld_q <= grant_vld_d;
    end
  end

endmodule

// File: tb/tb_intr_ctrl_v2.sv
// tb/tb_intr_ctrl_v2.sv - directed and randomized bench for intr_ctrl_v2
// Reference model follows the register and grant rules at cycle level.
module tb_intr_ctrl_v2;

  localparam int N = 16;

  logic        clk;
  logic        rst_n;
  logic [4:0]  paddr;
  logic [31:0] pwdata;
  logic        pwrite, psel, penable;
  logic [31:0] prdata_o;
  logic        pready_o, pslverr_o;
  logic [N-1:0] lines;
  logic [3:0]  intr_to_service_o;
  logic        intr_valid_o;
  logic        ack;

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0]   m_prio [N];
  logic [N-1:0] m_en, m_mode, m_pend, m_hist;
  logic         m_valid, m_arming;
  logic [3:0]   m_id;

  intr_ctrl_v2 dut (
    .pclk_i(clk), .prst_i(rst_n), .paddr_i(paddr), .pwdata_i(pwdata),
    .pwrite_i(pwrite), .psel_i(psel), .penable_i(penable),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .intr_active_i(lines), .intr_to_service_o(intr_to_service_o),
    .intr_valid_o(intr_valid_o), .intr_serviced_i(ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < N; n++) m_prio[n] = '0;
    m_en = '0; m_mode = '0; m_pend = '0; m_hist = '0;
    m_valid = 1'b0; m_arming = 1'b0; m_id = '0;
  endtask

  // Highest priority among enabled pending sources, lowest index on ties; -1 if none.
  function automatic int pick();
    int best = -1;
    int bp   = 0;
    for (int n = 0; n < N; n++)
      if (m_pend[n] && m_en[n] && int'(m_prio[n]) > bp) begin
        best = n;
        bp   = int'(m_prio[n]);
      end
    return best;
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a < 5'd16) return 32'(m_prio[a[3:0]]);
    case (a)
      5'd16:   return 32'(m_en);
      5'd17:   return 32'(m_mode);
      5'd18:   return 32'(m_pend);
      5'd19:   return {m_valid, 27'b0, m_id};
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    logic [N-1:0] nxt, clr;
    int  w;
    bit  acc_wr;
    acc_wr = psel && penable && pwrite && (paddr <= 5'd19);
    clr = '0;
    if (acc_wr && paddr == 5'd18) clr = pwdata[N-1:0] & m_mode;
    if (m_valid && ack) clr[m_id] = 1'b1;
    for (int n = 0; n < N; n++)
      nxt[n] = m_mode[n] ? ((lines[n] && !m_hist[n]) || (m_pend[n] && !clr[n])) : lines[n];
    w = pick();
    if (m_valid) begin
      if (ack) begin m_valid = 1'b0; m_id = '0; end
    end else if (m_arming) begin
      m_arming = 1'b0;
      if (w >= 0) begin m_valid = 1'b1; m_id = w[3:0]; end
    end else if (w >= 0) begin
      m_arming = 1'b1;
    end
    if (acc_wr) begin
      if (paddr < 5'd16)       m_prio[paddr[3:0]] = pwdata[3:0];
      else if (paddr == 5'd16) m_en   = pwdata[N-1:0];
      else if (paddr == 5'd17) m_mode = pwdata[N-1:0];
    end
    m_pend = nxt;
    m_hist = lines;
    @(posedge clk);
    #1;
    chk("valid", 32'(intr_valid_o), 32'(m_valid));
    chk("id", 32'(intr_to_service_o), 32'(m_id));
    chk("pready", 32'(pready_o), 32'(psel && penable));
    if (psel && penable) begin
      chk("pslverr", 32'(pslverr_o), 32'(paddr > 5'd19));
      if (!pwrite) chk("prdata", prdata_o, mread(paddr));
    end
  endtask

  task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
    psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
    tick();
    penable = 1'b1;
    #1;
    chk(tag, prdata_o, exp);
    chk({tag, "_err"}, 32'(pslverr_o), 32'(a > 5'd19));
    tick();
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  initial begin
    rst_n = 1'b1; paddr = '0; pwdata = '0; pwrite = 1'b0; psel = 1'b0; penable = 1'b0;
    lines = '0; ack = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #10;
    chk("rst_valid", 32'(intr_valid_o), 32'h0);
    chk("rst_id", 32'(intr_to_service_o), 32'h0);
    chk("rst_prdata", prdata_o, 32'h0);
    chk("rst_pslverr", 32'(pslverr_o), 32'h0);
    #10 rst_n = 1'b1;

    // Reset register contents, unmapped access, ignored writes
    for (int a = 0; a < 20; a++) read_chk("t1_reg", 5'(a), 32'h0);
    read_chk("t1_unmapped", 5'd20, 32'h0);
    apb_write(5'd19, 32'hffff_ffff);
    apb_write(5'd20, 32'hffff_ffff);
    read_chk("t1_status", 5'd19, 32'h0);
    read_chk("t1_enable", 5'd16, 32'h0);

    // Priority win, then fallback after acknowledge
    apb_write(5'd3, 32'd5);
    apb_write(5'd9, 32'd7);
    apb_write(5'd16, 32'h208);
    apb_write(5'd17, 32'h0);
    lines = 16'h0208;
    tick(); chk("t2_k0", 32'(intr_valid_o), 32'h0);
    tick(); chk("t2_k1", 32'(intr_valid_o), 32'h0);
    tick(); chk("t2_k2_valid", 32'(intr_valid_o), 32'h1);
    chk("t2_k2_id", 32'(intr_to_service_o), 32'd9);
    read_chk("t2_status", 5'd19, 32'h8000_0009);
    ack = 1'b1; lines[9] = 1'b0;
    tick(); ack = 1'b0;
    chk("t2_ack_drop", 32'(intr_valid_o), 32'h0);
    tick(); chk("t2_gap", 32'(intr_valid_o), 32'h0);
    tick(); chk("t2_next_id", 32'(intr_to_service_o), 32'd3);
    chk("t2_next_valid", 32'(intr_valid_o), 32'h1);
    ack = 1'b1; lines = '0;
    tick(); ack = 1'b0;
    ticks(2);

    // Equal priority tie-break
    apb_write(5'd2, 32'd4);
    apb_write(5'd6, 32'd4);
    apb_write(5'd16, 32'h44);
    lines = 16'h0044;
    ticks(3);
    chk("t3_tie_id", 32'(intr_to_service_o), 32'd2);
    chk("t3_tie_valid", 32'(intr_valid_o), 32'h1);
    ack = 1'b1; lines = '0;
    tick(); ack = 1'b0;
    ticks(2);

    // Edge source: pulse, acknowledge clear, W1C before arbitration
    apb_write(5'd5, 32'd1);
    apb_write(5'd17, 32'h20);
    apb_write(5'd16, 32'h20);
    lines = 16'h0020;
    tick(); lines = '0;
    read_chk("t4_pending", 5'd18, 32'h20);
    chk("t4_grant_id", 32'(intr_to_service_o), 32'd5);
    chk("t4_grant_valid", 32'(intr_valid_o), 32'h1);
    ack = 1'b1;
    tick(); ack = 1'b0;
    read_chk("t4_pend_clr", 5'd18, 32'h0);
    ticks(3);
    chk("t4_no_regrant", 32'(intr_valid_o), 32'h0);
    lines = 16'h0020;
    psel = 1'b1; pwrite = 1'b1; paddr = 5'd18; pwdata = 32'h20; penable = 1'b0;
    tick(); lines = '0; penable = 1'b1;
    tick(); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    ticks(2);
    chk("t4_w1c_nogrant", 32'(intr_valid_o), 32'h0);
    read_chk("t4_w1c_pend", 5'd18, 32'h0);

    // Grant stays fixed through reprogramming while waiting
    apb_write(5'd17, 32'h0);
    apb_write(5'd4, 32'd2);
    apb_write(5'd7, 32'd6);
    apb_write(5'd16, 32'h90);
    lines = 16'h0010;
    ticks(3);
    chk("t5_grant4", 32'(intr_to_service_o), 32'd4);
    apb_write(5'd4, 32'd0);
    lines = 16'h0090;
    ticks(2);
    chk("t5_hold_id", 32'(intr_to_service_o), 32'd4);
    chk("t5_hold_valid", 32'(intr_valid_o), 32'h1);
    ack = 1'b1;
    tick(); ack = 1'b0;
    chk("t5_ack", 32'(intr_valid_o), 32'h0);
    ticks(2);
    chk("t5_next_id", 32'(intr_to_service_o), 32'd7);
    chk("t5_next_valid", 32'(intr_valid_o), 32'h1);

    // Asynchronous reset while a grant is held
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(intr_valid_o), 32'h0);
    chk("t6_async_id", 32'(intr_to_service_o), 32'h0);
    model_reset();
    lines = '0;
    #13 rst_n = 1'b1;
    for (int a = 0; a < 20; a++) read_chk("t6_reg", 5'(a), 32'h0);

    // Randomized configuration and traffic with live PENDING readback
    for (int a = 0; a < N; a++) apb_write(5'(a), 32'($urandom_range(0, 15)));
    apb_write(5'd16, $urandom);
    apb_write(5'd17, $urandom);
    psel = 1'b1; penable = 1'b1; paddr = 5'd18;
    for (int i = 0; i < 400; i++) begin
      lines  = lines ^ N'($urandom & $urandom);
      ack    = ($urandom_range(0, 3) == 0);
      pwrite = ($urandom_range(0, 7) == 0);
      pwdata = $urandom;
      paddr  = ($urandom_range(0, 15) == 0) ? 5'(($urandom_range(16, 21))) : 5'd18;
      if (paddr == 5'd16 && pwrite) pwdata = pwdata | 32'h0000_ffff;
      tick();
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; ack = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
